// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Contents: transmit FSM state encoding, parity mode codes, and the
// mapping from the 2-bit baud select to a clocks-per-bit divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic [15:0] div_sel(input logic [1:0] s, input int d0, input int d1,
                                           input int d2, input int d3);
    logic [15:0] d;
    case (s)
      2'b00:   d = 16'(d0);
      2'b01:   d = 16'(d1);
      2'b10:   d = 16'(d2);
      default: d = 16'(d3);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART transmitter.
// Ports:
//   clk_in, rst_n        clock, asynchronous active-low reset
//   push_i / data_i      write request and word (ignored while full)
//   pop_i / data_o       read request and head word (head shown combinationally)
//   full_o, empty_o      occupancy flags (full is registered)
//   count_o              number of buffered words
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [DATA_BITS-1:0]    data_i,
  input  logic                    pop_i,
  output logic [DATA_BITS-1:0]    data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [PW:0]          cnt_q, cnt_d;
  logic                 full_q, do_push, do_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == FULL_CNT);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/uart_tx_param.sv
// Buffered, parametrised UART transmitter: words enter a FIFO over a
// valid/ready handshake and are serialised LSB-first with optional parity
// and one or two stop bits. Baud divisor, parity and stop count are
// sampled when a frame starts.
// Ports:
//   clk_in, reset                clock, asynchronous active-low reset
//   S, parity_mode, stop2        frame configuration
//   tx_valid/tx_ready/data_board word handshake into the FIFO
//   ser_out                      serial line, idle high
//   busy, fifo_count             status
//
// state  | meaning
// IDLE   | line high; pops next word when FIFO non-empty
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP1  | first stop bit (high)
// STOP2  | optional second stop bit (high)
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV0       = 16,
  parameter int DIV1       = 8,
  parameter int DIV2       = 4,
  parameter int DIV3       = 2
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [1:0]                   S,
  input  logic [1:0]                   parity_mode,
  input  logic                         stop2,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic [DATA_BITS-1:0]         data_board,
  output logic                         ser_out,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [15:0]          baud_q, baud_d, div_q, div_d, div_new;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic                 par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic                 ser_q, ser_d, busy_q;
  logic                 full, empty, push, pop;
  logic [CW-1:0]        cnt_nxt;

  assign push     = tx_valid && !full;
  assign tx_ready = !full;
  assign div_new  = div_sel(S, DIV0, DIV1, DIV2, DIV3);

  uart_tx_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (reset),
    .push_i  (push),
    .data_i  (data_board),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  // Occupancy after this edge, so busy is registered yet tracks the FIFO exactly.
  always_comb begin
    cnt_nxt = fifo_count;
    if (push && !pop)      cnt_nxt = fifo_count + CW'(1);
    else if (!push && pop) cnt_nxt = fifo_count - CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    pop       = 1'b0;
    if (state_q == IDLE) begin
      if (!empty) begin
        pop       = 1'b1;
        shift_d   = head;
        div_d     = div_new;
        baud_d    = div_new - 16'd1;
        bit_d     = '0;
        par_en_d  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_bit_d = (^head) ^ (parity_mode == PAR_ODD);
        stop2_d   = stop2;
        state_d   = START;
      end
    end else if (baud_q != '0) begin
      baud_d = baud_q - 16'd1;
    end else begin
      baud_d = div_q - 16'd1;
      case (state_q)
        START:  state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP1;
          else                   bit_d   = bit_q + BW'(1);
        end
        PARITY: state_d = STOP1;
        STOP1:  state_d = stop2_q ? STOP2 : IDLE;
        STOP2:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The line follows the current state one clock later, which gives the
  // two-cycle push-to-start-bit latency and keeps every bit DIV clocks wide.
  always_comb begin
    ser_d = 1'b1;
    case (state_q)
      START:   ser_d = 1'b0;
      DATA:    ser_d = shift_q[0];
      PARITY:  ser_d = par_bit_q;
      default: ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      ser_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      ser_q     <= ser_d;
      busy_q    <= (state_d != IDLE) || (cnt_nxt != '0);
    end
  end

  assign ser_out = ser_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] S = 2'b00;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] data_board = 8'h00;
  logic       ser_out;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  uart_tx_param #(
    .DATA_BITS (DATA_BITS), .FIFO_DEPTH (FIFO_DEPTH),
    .DIV0 (16), .DIV1 (8), .DIV2 (4), .DIV3 (2)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .S           (S),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .data_board  (data_board),
    .ser_out     (ser_out),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_div(input logic [1:0] s);
    case (s)
      2'b00:   return 16;
      2'b01:   return 8;
      2'b10:   return 4;
      default: return 2;
    endcase
  endfunction

  // Holds tx_valid until the word is accepted; returns cycles spent stalled.
  task automatic push_word(input logic [7:0] d, output int stalled);
    stalled = 0;
    data_board = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && stalled < 400) begin
      tick();
      stalled++;
    end
    check("push_ready", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s),
  // each held div clocks, followed by one idle-high clock.
  task automatic expect_frame(input string tag, input logic [7:0] d, input int div,
                              input logic [1:0] pm, input logic st2, output int waited);
    logic bits[$];
    waited = 0;
    while (ser_out !== 1'b0 && waited < 400) begin
      tick();
      waited++;
    end
    if (ser_out !== 1'b0) begin
      check({tag, "_start_timeout"}, ser_out, 0);
      return;
    end
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
    if (pm == 2'b01)      bits.push_back(^d);
    else if (pm == 2'b10) bits.push_back(~^d);
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    foreach (bits[j]) begin
      for (int c = 0; c < div; c++) begin
        check(tag, ser_out, bits[j]);
        tick();
      end
    end
    check({tag, "_idle_gap"}, ser_out, 1);
    tick();
  endtask

  initial begin
    int w, st, lows, busies;
    logic [7:0] words[6];
    logic [7:0] rd;
    logic [1:0] rs, rp;
    logic       rst2;

    // reset then idle
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_ser", ser_out, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);

    // basic frame, latency
    S = 2'b10; parity_mode = 2'b00; stop2 = 1'b0;
    push_word(8'hAA, st);
    check("lat_count", fifo_count, 1);
    check("lat_busy", busy, 1);
    check("lat_ser", ser_out, 1);
    expect_frame("basic", 8'hAA, 4, 2'b00, 1'b0, w);
    check("lat_start_edge", w, 2);
    check("basic_done_busy", busy, 0);
    check("basic_done_count", fifo_count, 0);

    // odd then even parity, two stop bits
    S = 2'b11; parity_mode = 2'b10; stop2 = 1'b1;
    push_word(8'h3C, st);
    expect_frame("par_odd", 8'h3C, 2, 2'b10, 1'b1, w);
    parity_mode = 2'b01;
    push_word(8'h3C, st);
    expect_frame("par_even", 8'h3C, 2, 2'b01, 1'b1, w);
    parity_mode = 2'b11;
    push_word(8'h5B, st);
    expect_frame("par_11_none", 8'h5B, 2, 2'b11, 1'b1, w);

    // FIFO full with tx_valid held
    S = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
    fork
      begin
        int sa;
        for (int i = 0; i < 6; i++) begin
          push_word(words[i], sa);
          if (i == 4) begin
            check("full_count", fifo_count, 4);
            check("full_ready_low", tx_ready, 0);
          end
          if (i == 5) check("full_sixth_stalled", (sa > 0), 1);
        end
      end
      begin
        int wb;
        for (int i = 0; i < 6; i++) begin
          expect_frame("full_frame", words[i], 2, 2'b00, 1'b0, wb);
          if (i > 0) check("full_back_to_back", wb, 0);
        end
      end
    join
    check("full_drained_busy", busy, 0);
    check("full_drained_count", fifo_count, 0);

    // config change mid-frame
    S = 2'b10; parity_mode = 2'b00; stop2 = 1'b0;
    push_word(8'h5A, st);
    push_word(8'hC3, st);
    fork
      begin
        int wa, wb;
        expect_frame("cfg_a", 8'h5A, 4, 2'b00, 1'b0, wa);
        expect_frame("cfg_b", 8'hC3, 16, 2'b00, 1'b0, wb);
        check("cfg_back_to_back", wb, 0);
      end
      begin
        repeat (6) tick();
        S = 2'b00;
      end
    join

    // reset mid-frame with two words queued
    S = 2'b10; parity_mode = 2'b00; stop2 = 1'b0;
    push_word(8'h00, st);
    push_word(8'h81, st);
    push_word(8'h7E, st);
    repeat (6) tick();
    check("pre_rst_count", fifo_count, 2);
    check("pre_rst_ser", ser_out, 0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ser", ser_out, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", tx_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    lows = 0;
    busies = 0;
    repeat (60) begin
      tick();
      if (ser_out !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    check("post_rst_line_quiet", lows, 0);
    check("post_rst_not_busy", busies, 0);

    // randomized frames against the reference
    for (int r = 0; r < 6; r++) begin
      rd   = 8'($urandom);
      rs   = 2'($urandom_range(0, 3));
      rp   = 2'($urandom_range(0, 3));
      rst2 = 1'($urandom_range(0, 1));
      S = rs; parity_mode = rp; stop2 = rst2;
      push_word(rd, st);
      expect_frame("rand_frame", rd, tb_div(rs), rp, rst2, w);
      check("rand_idle_busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
